// File: rtl/row_cache_pkg.sv
// Shared types and constants for the row cache slice.
package row_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    READY,
    DONE
  } cache_state_t;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned PIX_PER_WORD = 4;

endpackage

// File: rtl/line_ram.sv
// Line RAM: SLOTS x DEPTH words, one synchronous write port, RPORTS asynchronous
// read ports sharing a column index.
module line_ram
  import row_cache_pkg::*;
#(
  parameter int unsigned SLOTS  = 4,
  parameter int unsigned DEPTH  = 88,
  parameter int unsigned RPORTS = 3,
  parameter int unsigned SW     = 2,
  parameter int unsigned CW     = 7
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [SW-1:0]            wslot,
  input  logic [CW-1:0]            wcol,
  input  logic [WORD_W-1:0]        wdata,
  input  logic [RPORTS*SW-1:0]     rslot,
  input  logic [CW-1:0]            rcol,
  output logic [RPORTS*WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [SLOTS][DEPTH];

  // Capture one word per write strobe.
  always_ff @(posedge clk) begin
    if (we) mem[wslot][wcol] <= wdata;
  end

  // One read per window row, same column on every port.
  always_comb begin
    rdata = '0;
    for (int unsigned k = 0; k < RPORTS; k++) begin
      rdata[k*WORD_W +: WORD_W] = mem[rslot[k*SW +: SW]][rcol];
    end
  end

endmodule

// File: rtl/row_cache_n.sv
// ROWS-deep sliding window cache over a greyscale frame, with background
// prefetch of the next row into a spare slot and sequential result write-back.
module row_cache_n
  import row_cache_pkg::*;
#(
  parameter int unsigned WIDTH      = 352,
  parameter int unsigned HEIGHT     = 288,
  parameter int unsigned ROWS       = 3,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned OUT_BASE   = WIDTH / PIX_PER_WORD * HEIGHT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [WORD_W-1:0]        mem_di,
  input  logic [WORD_W-1:0]        mem_do,
  input  logic                     en,
  input  logic                     we,
  input  logic [WORD_W-1:0]        di,
  output logic [ROWS*WORD_W-1:0]   do_rows,
  output logic                     row_cached,
  output logic                     frame_done
);

  localparam int unsigned W   = WIDTH / PIX_PER_WORD;
  localparam int unsigned S   = ROWS + 1;
  localparam int unsigned SW  = $clog2(S);
  localparam int unsigned SW1 = SW + 1;
  localparam int unsigned CW  = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned RW  = $clog2(HEIGHT + ROWS + 2);

  cache_state_t            state, state_n;
  logic [RW-1:0]           top, top_n, loaded, loaded_n, irow;
  logic [SW-1:0]           top_slot, islot, cap_slot;
  logic [CW-1:0]           col, icol, cap_col;
  logic [ADDR_WIDTH-1:0]   raddr, wr_ptr;
  logic                    cap_v, cap_last;
  logic                    restart, wr_go, adv, wrap, rd_req, rd_go;
  logic [ROWS*SW-1:0]      rslot;
  logic [ROWS*WORD_W-1:0]  ram_rdata;

  // Request decode and port arbitration; a write always wins the port.
  always_comb begin
    restart = start && (state == IDLE || state == DONE);
    wr_go   = en && we && (state != IDLE);
    adv     = (state == READY) && en && !we && row_cached;
    wrap    = adv && (col == CW'(W - 1));
    rd_req  = ((state == FILL) && (irow < RW'(ROWS))) ||
              ((state == READY) && (irow < RW'(HEIGHT)) && (irow <= top + RW'(ROWS)));
    rd_go   = rd_req && !wr_go;
    mem_en   = wr_go || rd_go;
    mem_we   = wr_go;
    mem_addr = wr_go ? ADDR_WIDTH'(OUT_BASE) + wr_ptr : (rd_go ? raddr : '0);
    mem_di   = wr_go ? di : '0;
  end

  // Next frame state; loaded counts rows whose last word has been captured.
  always_comb begin
    state_n  = state;
    top_n    = top;
    loaded_n = loaded + RW'(cap_v && cap_last);
    case (state)
      IDLE, DONE: if (start) begin
        state_n  = FILL;
        top_n    = '0;
        loaded_n = '0;
      end
      FILL: if (loaded == RW'(ROWS)) state_n = READY;
      READY: if (wrap) begin
        top_n = top + RW'(1);
        if (top + RW'(ROWS) == RW'(HEIGHT)) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM, window position, write pointer and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      top        <= '0;
      top_slot   <= '0;
      col        <= '0;
      wr_ptr     <= '0;
      loaded     <= '0;
      row_cached <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      top        <= top_n;
      loaded     <= loaded_n;
      row_cached <= (state_n == READY) && (loaded_n >= top_n + RW'(ROWS));
      frame_done <= (state_n == DONE);
      if (restart) begin
        col      <= '0;
        wr_ptr   <= '0;
        top_slot <= '0;
      end else begin
        if (wr_go) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        if (adv)   col    <= wrap ? '0 : col + CW'(1);
        if (wrap)  top_slot <= (top_slot == SW'(S - 1)) ? '0 : top_slot + SW'(1);
      end
    end
  end

  // Read issue pointer and one-cycle capture tag. Reads run ahead of captures
  // across row boundaries so a fill streams without bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      irow     <= '0;
      icol     <= '0;
      islot    <= '0;
      raddr    <= '0;
      cap_v    <= 1'b0;
      cap_slot <= '0;
      cap_col  <= '0;
      cap_last <= 1'b0;
    end else begin
      cap_v    <= rd_go;
      cap_slot <= islot;
      cap_col  <= icol;
      cap_last <= (icol == CW'(W - 1));
      if (restart) begin
        irow  <= '0;
        icol  <= '0;
        islot <= '0;
        raddr <= '0;
      end else if (rd_go) begin
        raddr <= raddr + ADDR_WIDTH'(1);
        if (icol == CW'(W - 1)) begin
          icol  <= '0;
          irow  <= irow + RW'(1);
          islot <= (islot == SW'(S - 1)) ? '0 : islot + SW'(1);
        end else begin
          icol <= icol + CW'(1);
        end
      end
    end
  end

  // Window row k lives in slot (top_slot + k) mod S.
  always_comb begin
    logic [SW1-1:0] sum;
    rslot = '0;
    sum   = '0;
    for (int unsigned k = 0; k < ROWS; k++) begin
      sum = {1'b0, top_slot} + SW1'(k);
      if (sum >= SW1'(S)) sum = sum - SW1'(S);
      rslot[k*SW +: SW] = sum[SW-1:0];
    end
  end

  line_ram #(
    .SLOTS (S),
    .DEPTH (W),
    .RPORTS(ROWS),
    .SW    (SW),
    .CW    (CW)
  ) u_line_ram (
    .clk  (clk),
    .we   (cap_v),
    .wslot(cap_slot),
    .wcol (cap_col),
    .wdata(mem_do),
    .rslot(rslot),
    .rcol (col),
    .rdata(ram_rdata)
  );

  assign do_rows = (state == READY) ? ram_rdata : '0;

endmodule

// File: tb/tb_row_cache_n.sv
// Bench for row_cache_n: a 352x288x3 instance and an 8x6x5 instance, each with a
// memory model returning word a at address a and a write-back scoreboard.
module tb_row_cache_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Large instance (defaults: W=88, OUT_BASE=25344)
  logic        a_start, a_en, a_we, a_mem_en, a_mem_we, a_row_cached, a_frame_done;
  logic [31:0] a_di, a_mem_di, a_mem_do;
  logic [15:0] a_mem_addr;
  logic [95:0] a_do_rows;
  // Small instance (W=2, OUT_BASE=12)
  logic         b_start, b_en, b_we, b_mem_en, b_mem_we, b_row_cached, b_frame_done;
  logic [31:0]  b_di, b_mem_di, b_mem_do;
  logic [15:0]  b_mem_addr;
  logic [159:0] b_do_rows;

  row_cache_n dut_a (
    .clk(clk), .rst(rst), .start(a_start), .mem_en(a_mem_en), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_di(a_mem_di), .mem_do(a_mem_do), .en(a_en), .we(a_we),
    .di(a_di), .do_rows(a_do_rows), .row_cached(a_row_cached), .frame_done(a_frame_done)
  );

  row_cache_n #(.WIDTH(8), .HEIGHT(6), .ROWS(5)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_di(b_mem_di), .mem_do(b_mem_do), .en(b_en), .we(b_we),
    .di(b_di), .do_rows(b_do_rows), .row_cached(b_row_cached), .frame_done(b_frame_done)
  );

  // Memory models: 1-cycle read latency, word value equals its address.
  always @(posedge clk) if (a_mem_en && !a_mem_we) a_mem_do <= 32'(a_mem_addr);
  always @(posedge clk) if (b_mem_en && !b_mem_we) b_mem_do <= 32'(b_mem_addr);

  // Scoreboards: expected {addr, data} of each write; reads must be sequential from 0.
  logic [47:0] a_q[$], b_q[$];
  logic [47:0] a_exp, b_exp;
  int unsigned a_wptr = 0, b_wptr = 0;
  int unsigned a_rd_cnt = 0, a_rd_org = 0, b_rd_cnt = 0, b_rd_org = 0;

  always @(negedge clk) begin
    if (a_mem_en && a_mem_we) begin
      checks++;
      if (a_q.size() == 0) begin
        errors++;
        $display("FAIL a_write_unexpected addr=%0d data=%h", a_mem_addr, a_mem_di);
      end else begin
        a_exp = a_q.pop_front();
        if ({a_mem_addr, a_mem_di} !== a_exp) begin
          errors++;
          $display("FAIL a_write got addr=%0d data=%h want addr=%0d data=%h",
                   a_mem_addr, a_mem_di, a_exp[47:32], a_exp[31:0]);
        end
      end
    end else if (a_mem_en) begin
      checks++;
      if (a_mem_addr !== 16'(a_rd_cnt - a_rd_org)) begin
        errors++;
        $display("FAIL a_read_order got %0d want %0d", a_mem_addr, a_rd_cnt - a_rd_org);
      end
      a_rd_cnt++;
    end
  end

  always @(negedge clk) begin
    if (b_mem_en && b_mem_we) begin
      checks++;
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_write_unexpected addr=%0d data=%h", b_mem_addr, b_mem_di);
      end else begin
        b_exp = b_q.pop_front();
        if ({b_mem_addr, b_mem_di} !== b_exp) begin
          errors++;
          $display("FAIL b_write got addr=%0d data=%h want addr=%0d data=%h",
                   b_mem_addr, b_mem_di, b_exp[47:32], b_exp[31:0]);
        end
      end
    end else if (b_mem_en) begin
      checks++;
      if (b_mem_addr !== 16'(b_rd_cnt - b_rd_org)) begin
        errors++;
        $display("FAIL b_read_order got %0d want %0d", b_mem_addr, b_rd_cnt - b_rd_org);
      end
      b_rd_cnt++;
    end
  end

  function automatic logic [95:0] exp_a(input int unsigned t, input int unsigned c);
    logic [95:0] r;
    for (int unsigned k = 0; k < 3; k++) r[k*32 +: 32] = 32'((t + k) * 88 + c);
    return r;
  endfunction

  function automatic logic [159:0] exp_b(input int unsigned t, input int unsigned c);
    logic [159:0] r;
    for (int unsigned k = 0; k < 5; k++) r[k*32 +: 32] = 32'((t + k) * 2 + c);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({a_mem_en, a_mem_we, a_row_cached, a_frame_done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_a_flags got %b want 0000",
               {a_mem_en, a_mem_we, a_row_cached, a_frame_done});
    end
    checks++;
    if ({a_mem_addr, a_mem_di, a_do_rows} !== '0) begin
      errors++;
      $display("FAIL reset_a_data got addr=%0d di=%h rows=%h want 0", a_mem_addr, a_mem_di, a_do_rows);
    end
    checks++;
    if ({b_mem_en, b_mem_we, b_row_cached, b_frame_done, b_mem_addr, b_do_rows} !== '0) begin
      errors++;
      $display("FAIL reset_b got en=%b rc=%b fd=%b rows=%h want 0",
               b_mem_en, b_row_cached, b_frame_done, b_do_rows);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill;
    int n;
    a_rd_org = a_rd_cnt;
    a_wptr = 0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    n = 0;
    while (!a_row_cached && n < 400) begin
      a_en = (n >= 10 && n < 30);
      a_we = 1'b0;
      tick();
      n++;
    end
    a_en = 1'b0;
    checks++;
    if (n != 266) begin
      errors++;
      $display("FAIL fill_latency got %0d want 266", n);
    end
    checks++;
    if (a_do_rows !== {32'd176, 32'd88, 32'd0}) begin
      errors++;
      $display("FAIL fill_window got %h want %h", a_do_rows, {32'd176, 32'd88, 32'd0});
    end
  endtask

  task automatic test_advance;
    for (int unsigned i = 0; i < 88; i++) begin
      a_en = 1'b0;
      tick();
      checks++;
      if (a_row_cached !== 1'b1 || a_do_rows !== exp_a(0, i)) begin
        errors++;
        $display("FAIL adv_col%0d got rc=%b rows=%h want rc=1 rows=%h", i, a_row_cached, a_do_rows, exp_a(0, i));
      end
      a_en = 1'b1;
      a_we = 1'b0;
      tick();
    end
    checks++;
    if (a_row_cached !== 1'b1 || a_do_rows !== {32'd264, 32'd176, 32'd88}) begin
      errors++;
      $display("FAIL adv_wrap got rc=%b rows=%h want rc=1 rows=%h", a_row_cached, a_do_rows,
               {32'd264, 32'd176, 32'd88});
    end
  endtask

  // Called straight after the wrap so the first prefetch read of row 4 is pre-empted.
  task automatic test_write_preempt;
    int n;
    int bad;
    for (int unsigned i = 0; i < 100; i++) begin
      a_en = 1'b1;
      a_we = 1'b1;
      a_di = $urandom;
      a_q.push_back({16'(25344 + a_wptr), a_di});
      a_wptr++;
      tick();
    end
    bad = 0;
    for (int unsigned i = 0; i < 88; i++) begin
      a_en = 1'b1;
      a_we = 1'b0;
      if (a_row_cached !== 1'b1) bad++;
      tick();
    end
    a_en = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL preempt_window_held got %0d dropped cycles want 0", bad);
    end
    checks++;
    if (a_row_cached !== 1'b0) begin
      errors++;
      $display("FAIL preempt_gap_low got rc=%b want 0", a_row_cached);
    end
    n = 0;
    while (!a_row_cached && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL preempt_gap_len got %0d want 1", n);
    end
    for (int unsigned i = 0; i < 88; i++) begin
      checks++;
      if (a_do_rows !== exp_a(2, i)) begin
        errors++;
        $display("FAIL preempt_col%0d got %h want %h", i, a_do_rows, exp_a(2, i));
      end
      if (i < 87) begin
        a_en = 1'b1;
        tick();
        a_en = 1'b0;
        tick();
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    a_en = 1'b1;
    a_we = 1'b0;
    tick();
    a_en = 1'b0;
    checks++;
    if (a_mem_en !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 16'd528) begin
      errors++;
      $display("FAIL rstmid_prefetch got en=%b we=%b addr=%0d want 1 0 528", a_mem_en, a_mem_we, a_mem_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({a_mem_en, a_mem_we, a_row_cached, a_frame_done, a_mem_addr, a_mem_di, a_do_rows} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got en=%b rc=%b addr=%0d rows=%h want 0",
               a_mem_en, a_row_cached, a_mem_addr, a_do_rows);
    end
    tick();
    checks++;
    if (a_mem_en !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle got en=%b want 0", a_mem_en);
    end
    a_rd_org = a_rd_cnt;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    n = 0;
    while (!a_row_cached && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n != 266 || a_do_rows !== {32'd176, 32'd88, 32'd0}) begin
      errors++;
      $display("FAIL rstmid_refill got n=%0d rows=%h want 266 %h", n, a_do_rows, {32'd176, 32'd88, 32'd0});
    end
  endtask

  task automatic test_frame_end;
    int n;
    b_rd_org = b_rd_cnt;
    b_wptr = 0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    n = 0;
    while (!b_row_cached && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 12 || b_do_rows !== exp_b(0, 0)) begin
      errors++;
      $display("FAIL frame_fill got n=%0d rows=%h want 12 %h", n, b_do_rows, exp_b(0, 0));
    end
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    checks++;
    if (b_row_cached !== 1'b1 || b_do_rows !== exp_b(0, 0)) begin
      errors++;
      $display("FAIL frame_start_ignored got rc=%b rows=%h want 1 %h", b_row_cached, b_do_rows, exp_b(0, 0));
    end
    for (int unsigned i = 0; i < 2; i++) begin
      b_en = 1'b1;
      b_we = 1'b1;
      b_di = $urandom;
      b_q.push_back({16'(12 + b_wptr), b_di});
      b_wptr++;
      tick();
    end
    b_en = 1'b0;
    b_we = 1'b0;
    for (int unsigned p = 0; p < 4; p++) begin
      n = 0;
      while (!b_row_cached && n < 50) begin
        tick();
        n++;
      end
      checks++;
      if (b_row_cached !== 1'b1 || b_frame_done !== 1'b0 || b_do_rows !== exp_b(p / 2, p % 2)) begin
        errors++;
        $display("FAIL frame_win%0d got rc=%b fd=%b rows=%h want 1 0 %h", p, b_row_cached, b_frame_done,
                 b_do_rows, exp_b(p / 2, p % 2));
      end
      b_en = 1'b1;
      tick();
      b_en = 1'b0;
    end
    checks++;
    if (b_frame_done !== 1'b1 || b_row_cached !== 1'b0) begin
      errors++;
      $display("FAIL frame_done got fd=%b rc=%b want 1 0", b_frame_done, b_row_cached);
    end
    b_en = 1'b1;
    b_we = 1'b1;
    b_di = $urandom;
    b_q.push_back({16'(12 + b_wptr), b_di});
    tick();
    b_wptr = 0;
    b_rd_org = b_rd_cnt;
    b_en = 1'b0;
    b_we = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_en = 1'b1;
    b_we = 1'b1;
    b_di = $urandom;
    b_q.push_back({16'(12 + b_wptr), b_di});
    b_wptr++;
    tick();
    b_en = 1'b0;
    b_we = 1'b0;
    n = 1;
    while (!b_row_cached && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 13 || b_frame_done !== 1'b0 || b_do_rows !== exp_b(0, 0)) begin
      errors++;
      $display("FAIL frame_restart got n=%0d fd=%b rows=%h want 13 0 %h", n, b_frame_done, b_do_rows, exp_b(0, 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    {a_start, a_en, a_we, b_start, b_en, b_we} = '0;
    a_di = '0;
    b_di = '0;
    test_reset();
    test_fill();
    test_advance();
    test_write_preempt();
    test_reset_mid();
    test_frame_end();
    tick();
    checks++;
    if (a_q.size() != 0 || b_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got a=%0d b=%0d pending want 0", a_q.size(), b_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
